bus_alu_datapath: RTL
=====================

BUS_ALU_DATAPATH -- requirements
Module: bus_alu_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning datapath/register width in bits (legal range 4-32).
REQ-002 SHALL have parameter NREGS, default 4, meaning register-file depth, with r0 as the accumulator (legal range 2-16).
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1, command present.
REQ-006 SHALL have port cmd_ready, output, 1, block can accept a command.
REQ-007 SHALL have port cmd_op, input, 3, opcode per REQ-012.
REQ-008 SHALL have ports cmd_dst and cmd_src, input, 4 each, register indices.
REQ-009 SHALL have port cmd_imm, input, WIDTH, immediate for LDI.
REQ-010 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, WIDTH) and rsp_err (output, 1), forming the response channel.
REQ-011 SHALL have ports acc_out (output, WIDTH), a live copy of r0, and flags (output, 3), {NF,ZF,CF}.

Function
REQ-012 SHALL implement opcodes:
- 0 READ: rsp_data = r[src].
- 1 LDI: r[dst] = imm.
- 2 MOV: r[dst] = r[src].
- 3 ADD: r0 = r0 + r[src].
- 4 SUB: r0 = r0 - r[src].
- 5 AND, 6 OR, 7 XOR: r0 = r0 op r[src].
REQ-013 SHALL use the FSM IDLE -> OPND -> EXEC -> RESP -> IDLE; cmd_ready SHALL be 1 only in IDLE.
REQ-014 SHALL accept a command on a clk edge with cmd_valid && cmd_ready, latch all cmd fields, and go IDLE -> OPND.
REQ-015 In OPND the block SHALL latch r[src] into an internal WIDTH-bit operand bus register; next state EXEC.
REQ-016 In EXEC the block SHALL compute the result, write back the destination and update flags on the same edge, enter RESP, and set rsp_valid=1.
- Accept-to-rsp_valid latency is exactly 3 clk edges.
REQ-017 In RESP the block SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_valid && rsp_ready on an edge, then return to IDLE. Minimum command-to-command spacing is 4 cycles.
REQ-018 rsp_data SHALL equal the value written (LDI/MOV/ALU ops) or the value read (READ).
REQ-019 ADD/SUB SHALL compute at WIDTH+1 bits.
- CF = carry-out for ADD; CF = borrow (r0 < r[src], unsigned) for SUB.
- ZF = result==0.
- NF = result MSB.
REQ-020 AND/OR/XOR SHALL update ZF and NF and clear CF; READ/LDI/MOV SHALL leave flags unchanged.
REQ-021 A command whose used index (src and/or dst) is >= NREGS SHALL still complete with latency per REQ-016 but SHALL:
- set rsp_err=1 and rsp_data=0;
- modify no register or flag.
REQ-022 A write to r0 via LDI/MOV SHALL update acc_out on the EXEC edge; acc_out SHALL otherwise track r0 continuously.
REQ-023 cmd_valid asserted outside IDLE SHALL be ignored, with no queuing.
REQ-024 For src==0 the block SHALL use r0's value at the OPND edge, e.g. ADD r0,r0 doubles r0.

Reset
REQ-025 While rst=1, the block SHALL asynchronously force: FSM=IDLE, all registers=0, flags=0, rsp_valid=0, rsp_err=0, rsp_data=0, acc_out=0.
REQ-026 cmd_ready SHALL be 0 while rst=1 and 1 from the first clk cycle after deassertion.
REQ-027 rst asserted mid-command SHALL abort it, with no write-back and no response.

Configuration
REQ-028 Macro BUS_ALU_SATURATE_EN SHALL select saturation behaviour:
- Defined: ADD result clamps to all-ones on carry, SUB clamps to 0 on borrow; CF still reports the overflow/borrow, and ZF/NF reflect the clamped result.
- Undefined: ADD/SUB wrap modulo 2^WIDTH.

Verification (WIDTH=8, NREGS=4)
REQ-029 Reset, then LDI r1,0x05; ADD r1 -> rsp_data=0x05, acc_out=0x05, flags=000, rsp_valid exactly 3 edges after each accept.
REQ-030 r0=0xF0, r1=0x20, ADD r1 -> wrap build: 0x10, CF=1; BUS_ALU_SATURATE_EN build: 0xFF, CF=1, NF=1.
REQ-031 r0=0x03, r1=0x05, SUB r1 -> wrap: 0xFE, CF=1, NF=1; saturate: 0x00, ZF=1, CF=1.
REQ-032 READ src=7 -> rsp_err=1, rsp_data=0, registers/flags unchanged; a later LDI r2,0xAA -> READ r2 returns 0xAA, rsp_err=0.
REQ-033 Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_valid/data stable, cmd_ready=0, second command not accepted until cycle after rsp handshake.
REQ-034 Assert rst during EXEC of LDI r0,0x55 -> acc_out=0, rsp_valid=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/bus_alu_datapath.sv
// ---------------------------------------------------------------------------
// bus_alu_datapath
// Small register-file ALU behind a valid/ready command channel and a
// valid/ready response channel. r0 is the accumulator for ADD/SUB/AND/OR/XOR.
// Each command walks IDLE -> OPND -> EXEC -> RESP -> IDLE.
//
// Parameters
//   WIDTH  datapath / register width (4..32)
//   NREGS  register-file depth, r0 = accumulator (2..16)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  block can accept a command (IDLE only)
//   cmd_op     opcode: 0 READ, 1 LDI, 2 MOV, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR
//   cmd_dst    destination register index (LDI/MOV)
//   cmd_src    source register index (READ/MOV/ALU ops)
//   cmd_imm    immediate for LDI
//   rsp_valid  response present, held until rsp_ready
//   rsp_ready  response consumer ready
//   rsp_data   value written, or value read for READ; 0 on error
//   rsp_err    an index used by the command was >= NREGS
//   acc_out    live copy of r0
//   flags      {NF, ZF, CF}
//
// Build option
//   BUS_ALU_SATURATE_EN  defined: ADD clamps to all-ones on carry and SUB
//                        clamps to 0 on borrow. Undefined: both wrap.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cmd_ready=1, waiting for cmd_valid
// OPND  | latch r[src] onto the operand bus register
// EXEC  | compute, write back, update flags, raise rsp_valid
// RESP  | hold response until rsp_ready
// ---------------------------------------------------------------------------
module bus_alu_datapath #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_dst,
    input  logic [3:0]       cmd_src,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc_out,
    output logic [2:0]       flags
);

    typedef enum logic [1:0] {IDLE, OPND, EXEC, RESP} state_t;

    localparam logic [2:0] OP_READ = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_MOV  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    // 5 bits so NREGS=16 is representable
    localparam logic [4:0] NREGS_L = 5'(NREGS);

    state_t           state;
    logic [2:0]       op_q;
    logic [3:0]       dst_q;
    logic [3:0]       src_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] regs [NREGS];
    logic             nf, zf, cf;

    logic             src_bad, dst_bad, uses_src, uses_dst, cmd_err;
    logic [WIDTH-1:0] res;
    logic             we, flag_upd, cf_n;
    logic [3:0]       widx;
    logic [WIDTH:0]   sum, diff;

    assign acc_out = regs[0];
    assign flags   = {nf, zf, cf};

    function automatic logic [WIDTH-1:0] rd_reg(input logic [3:0] idx);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == 4'(i)) v = regs[i];
        end
        return v;
    endfunction

    assign src_bad  = {1'b0, src_q} >= NREGS_L;
    assign dst_bad  = {1'b0, dst_q} >= NREGS_L;
    assign uses_src = (op_q != OP_LDI);
    assign uses_dst = (op_q == OP_LDI) || (op_q == OP_MOV);
    assign cmd_err  = (uses_src && src_bad) || (uses_dst && dst_bad);

    // r0 cannot change between OPND and EXEC, so regs[0] here is r0 as seen
    // at the OPND edge (ADD r0,r0 doubles r0).
    assign sum  = {1'b0, regs[0]} + {1'b0, opnd_q};
    assign diff = {1'b0, regs[0]} - {1'b0, opnd_q};

    always_comb begin
        res      = '0;
        we       = 1'b0;
        flag_upd = 1'b0;
        cf_n     = 1'b0;
        widx     = 4'd0;
        case (op_q)
            OP_READ: res = opnd_q;
            OP_LDI: begin
                res  = imm_q;
                we   = 1'b1;
                widx = dst_q;
            end
            OP_MOV: begin
                res  = opnd_q;
                we   = 1'b1;
                widx = dst_q;
            end
            OP_ADD: begin
                cf_n = sum[WIDTH];
`ifdef BUS_ALU_SATURATE_EN
                res  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                res  = sum[WIDTH-1:0];
`endif
                we       = 1'b1;
                flag_upd = 1'b1;
            end
            OP_SUB: begin
                cf_n = diff[WIDTH];
`ifdef BUS_ALU_SATURATE_EN
                res  = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
                res  = diff[WIDTH-1:0];
`endif
                we       = 1'b1;
                flag_upd = 1'b1;
            end
            OP_AND: begin
                res      = regs[0] & opnd_q;
                we       = 1'b1;
                flag_upd = 1'b1;
            end
            OP_OR: begin
                res      = regs[0] | opnd_q;
                we       = 1'b1;
                flag_upd = 1'b1;
            end
            OP_XOR: begin
                res      = regs[0] ^ opnd_q;
                we       = 1'b1;
                flag_upd = 1'b1;
            end
            default: res = '0;
        endcase
        if (cmd_err) begin
            res      = '0;
            we       = 1'b0;
            flag_upd = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            op_q      <= '0;
            dst_q     <= '0;
            src_q     <= '0;
            imm_q     <= '0;
            opnd_q    <= '0;
            nf        <= 1'b0;
            zf        <= 1'b0;
            cf        <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        dst_q     <= cmd_dst;
                        src_q     <= cmd_src;
                        imm_q     <= cmd_imm;
                        cmd_ready <= 1'b0;
                        state     <= OPND;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                OPND: begin
                    opnd_q <= src_bad ? '0 : rd_reg(src_q);
                    state  <= EXEC;
                end
                EXEC: begin
                    if (we) begin
                        for (int i = 0; i < NREGS; i++) begin
                            if (widx == 4'(i)) regs[i] <= res;
                        end
                    end
                    if (flag_upd) begin
                        nf <= res[WIDTH-1];
                        zf <= (res == '0);
                        cf <= cf_n;
                    end
                    rsp_data  <= res;
                    rsp_err   <= cmd_err;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
